mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_if.sv | 38 +++
 rtl/mem_access_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_if
//  Description : Request/ack bus between the MEM stage and the data-memory
//                wrapper. Only one transaction is outstanding at a time.
//  Signals     : dm_req   - request valid, held until dm_ack
//                dm_we    - 1 = write, 0 = read
//                dm_addr  - word-aligned byte address
//                dm_wstrb - active-high byte strobes
//                dm_wdata - lane-replicated store data
//                dm_ack   - transaction complete, dm_rdata valid this cycle
//                dm_rdata - read word
//  Modports    : master (MEM stage), slave (memory wrapper)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_ack;
    logic [DATA_W-1:0]     dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM stage of the 5-stage RV32I pipeline. Turns EX/MEM memory
//                control into a single-outstanding request/ack transaction,
//                stalls the pipeline while it is in flight, and returns
//                aligned, sign/zero-extended load data to MEM/WB.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_mem_ctrl      - [1]=MemRead, [0]=MemWrite (11 = write)
//                i_addr          - byte address from the ALU
//                i_wdata         - store data
//                i_funct3        - access size / signedness
//                dm              - data-memory bus (master modport)
//                o_load_data     - extended load result
//                o_mem_stall     - freeze PC, IF/ID, ID/EX, EX/MEM
//                o_misalign      - one-cycle misaligned-access pulse
//  Options     : MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses are suppressed and flagged on o_misalign; when
//                undefined, o_misalign is 0 and low address bits beyond the
//                access size are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // fixed at 32
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire  [1:0]           i_mem_ctrl,
    input  wire  [ADDR_W-1:0]    i_addr,
    input  wire  [DATA_W-1:0]    i_wdata,
    input  wire  [2:0]           i_funct3,
    mem_access_stage_if.master   dm,
    output logic [DATA_W-1:0]    o_load_data,
    output logic                 o_mem_stall,
    output logic                 o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_wstrb;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_funct3;
    logic [1:0]          r_ofs;
    logic [DATA_W-1:0]   r_load_data;
`ifdef MISALIGN_TRAP_EN
    logic                r_misalign;
`endif

    logic                w_access;
    logic                w_is_write;
    logic                w_misaligned;
    logic                w_start;
    logic [3:0]          w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load_ext;

    assign w_access   = (i_mem_ctrl != 2'b00);
    assign w_is_write = i_mem_ctrl[0];          // 2'b11 resolves to a write

`ifdef MISALIGN_TRAP_EN
    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
    always_comb begin
        w_misaligned = 1'b0;
        if (i_funct3 == 3'b001 || (!w_is_write && i_funct3 == 3'b101))
            w_misaligned = i_addr[0];
        else if (i_funct3 == 3'b010)
            w_misaligned = |i_addr[1:0];
    end
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_start = (r_state == S_IDLE) && w_access && !w_misaligned;

    // Gated by rst so the pipeline is released the instant reset hits.
    assign o_mem_stall = !rst && (w_start || (r_state == S_BUSY));

    // Store lane steering; reads never drive strobes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = i_wdata;
        case (i_funct3)
            3'b000: begin
                w_wstrb = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            3'b001: begin
                w_wstrb = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
            3'b010: begin
                w_wstrb = 4'b1111;
            end
            default: begin
                w_wstrb = 4'b0000;
            end
        endcase
        if (!w_is_write)
            w_wstrb = 4'b0000;
    end

    // Load extraction keyed on the offset/funct3 captured at issue time.
    assign w_byte = dm.dm_rdata[{r_ofs, 3'b000} +: 8];
    assign w_half = r_ofs[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

    always_comb begin
        w_load_ext = dm.dm_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = dm.dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_ofs       <= 2'b00;
            r_load_data <= '0;
`ifdef MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_req    <= 1'b1;
                        r_we     <= w_is_write;
                        r_addr   <= {i_addr[ADDR_W-1:2], 2'b00};
                        r_wstrb  <= w_wstrb;
                        r_wdata  <= w_wdata;
                        r_funct3 <= i_funct3;
                        r_ofs    <= i_addr[1:0];
                        r_state  <= S_BUSY;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (w_access && w_misaligned) begin
                        r_misalign  <= 1'b1;
                        r_load_data <= '0;
                    end
`endif
                end
                S_BUSY: begin
                    if (dm.dm_ack) begin
                        r_req <= 1'b0;
                        if (!r_we)
                            r_load_data <= w_load_ext;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dm.dm_req    = r_req;
    assign dm.dm_we     = r_we;
    assign dm.dm_addr   = r_addr;
    assign dm.dm_wstrb  = r_wstrb;
    assign dm.dm_wdata  = r_wdata;
    assign o_load_data  = r_load_data;
`ifdef MISALIGN_TRAP_EN
    assign o_misalign   = r_misalign;
`else
    assign o_misalign   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_ctrl = 2'b00;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] load_data;
    logic        mem_stall;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage_if u_if ();

    always #5 clk = ~clk;

    mem_access_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem_ctrl  (mem_ctrl),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_funct3    (funct3),
        .dm          (u_if.master),
        .o_load_data (load_data),
        .o_mem_stall (mem_stall),
        .o_misalign  (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full access: IDLE issue, nb BUSY cycles without ack, ack, DONE.
    task automatic access(input string nm, input logic [1:0] ctrl, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rd,
                          input int nb, input logic exp_we, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_load);
        int stalls;
        stalls = 0;
        @(posedge clk); #1;
        mem_ctrl = ctrl; addr = a; wdata = wd; funct3 = f3; u_if.dm_rdata = rd;
        @(negedge clk);
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        // Garbage on the inputs while BUSY must be ignored.
        mem_ctrl = 2'b00; addr = 32'hFFFF_FFFF; wdata = 32'h0; funct3 = 3'b111;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            @(posedge clk); #1;
        end
        u_if.dm_ack = 1'b1;
        @(negedge clk);
        if (mem_stall) stalls++;
        check({nm, "/req"},   {31'd0, u_if.dm_req}, 32'd1);
        check({nm, "/we"},    {31'd0, u_if.dm_we},  {31'd0, exp_we});
        check({nm, "/addr"},  u_if.dm_addr,         exp_addr);
        check({nm, "/wstrb"}, {28'd0, u_if.dm_wstrb}, {28'd0, exp_strb});
        check({nm, "/wdata"}, u_if.dm_wdata,        exp_wdata);
        @(posedge clk); #1;
        u_if.dm_ack = 1'b0;
        @(negedge clk);
        check({nm, "/done_stall"}, {31'd0, mem_stall}, 32'd0);
        check({nm, "/done_req"},   {31'd0, u_if.dm_req}, 32'd0);
        check({nm, "/stall_cycles"}, stalls, 2 + nb);
        if (!exp_we)
            check({nm, "/load"}, load_data, exp_load);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.dm_ack   = 1'b0;
        u_if.dm_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst/req",   {31'd0, u_if.dm_req},   32'd0);
        check("rst/we",    {31'd0, u_if.dm_we},    32'd0);
        check("rst/addr",  u_if.dm_addr,           32'd0);
        check("rst/wstrb", {28'd0, u_if.dm_wstrb}, 32'd0);
        check("rst/wdata", u_if.dm_wdata,          32'd0);
        check("rst/load",  load_data,              32'd0);
        check("rst/mis",   {31'd0, misalign},      32'd0);
        check("rst/stall", {31'd0, mem_stall},     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //      name   ctrl   addr          wdata         f3      rdata         nb we  exp_addr      strb     exp_wdata     exp_load
        access("SW",   2'b01, 32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 32'h0,        2, 1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("SB",   2'b01, 32'h0000_0103, 32'h0000_00A5, 3'b000, 32'h0,        0, 1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("SH",   2'b01, 32'h0000_0102, 32'h0000_BEEF, 3'b001, 32'h0,        1, 1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        access("S011", 2'b11, 32'h0000_0108, 32'h1234_5678, 3'b011, 32'h0,        0, 1, 32'h0000_0108, 4'b0000, 32'h1234_5678, 32'h0);
        access("LB",   2'b10, 32'h0000_0101, 32'h0,         3'b000, 32'h1234_80FF, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_FF80);
        access("LBU",  2'b10, 32'h0000_0101, 32'h0,         3'b100, 32'h1234_80FF, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_0080);
        access("LH",   2'b10, 32'h0000_0102, 32'h0,         3'b001, 32'h8001_0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_8001);
        access("LHU",  2'b10, 32'h0000_0102, 32'h0,         3'b101, 32'h8001_0000, 3, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_8001);
        access("LW",   2'b10, 32'h0000_0100, 32'h0,         3'b010, 32'h8001_0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'h8001_0000);

        // Non-memory instructions: load_data holds, no stall, no request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold/load",  load_data,              32'h8001_0000);
        check("hold/stall", {31'd0, mem_stall},     32'd0);
        check("hold/req",   {31'd0, u_if.dm_req},   32'd0);

`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        mem_ctrl = 2'b10; addr = 32'h0000_0102; funct3 = 3'b010; u_if.dm_rdata = 32'h1357_9BDF;
        @(negedge clk);
        check("mis/stall", {31'd0, mem_stall},   32'd0);
        @(posedge clk); #1;
        mem_ctrl = 2'b00;
        check("mis/pulse", {31'd0, misalign},    32'd1);
        check("mis/req",   {31'd0, u_if.dm_req}, 32'd0);
        check("mis/load",  load_data,            32'd0);
        @(posedge clk); #1;
        check("mis/pulse_end", {31'd0, misalign},  32'd0);
        check("mis/stall2",    {31'd0, mem_stall}, 32'd0);
`else
        access("LWmis", 2'b10, 32'h0000_0102, 32'h0, 3'b010, 32'h1357_9BDF, 0, 0, 32'h0000_0100, 4'b0000, 32'h0, 32'h1357_9BDF);
        check("mis/off", {31'd0, misalign}, 32'd0);
`endif

        // Reset in the middle of a transaction, then a late ack.
        @(posedge clk); #1;
        mem_ctrl = 2'b10; addr = 32'h0000_0200; funct3 = 3'b010; u_if.dm_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_ctrl = 2'b00;
        @(negedge clk);
        check("mrst/req_busy",   {31'd0, u_if.dm_req}, 32'd1);
        check("mrst/stall_busy", {31'd0, mem_stall},   32'd1);
        #2 rst = 1'b1;
        #1;
        check("mrst/req",   {31'd0, u_if.dm_req}, 32'd0);
        check("mrst/stall", {31'd0, mem_stall},   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        u_if.dm_ack = 1'b1;
        @(posedge clk); #1;
        u_if.dm_ack = 1'b0;
        @(negedge clk);
        check("mrst/late_load",  load_data,            32'd0);
        check("mrst/late_req",   {31'd0, u_if.dm_req}, 32'd0);
        check("mrst/late_stall", {31'd0, mem_stall},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
